// File: rtl/lock_status_ctrl.sv
// Door/lockout supervisor sitting behind the combination-lock sequence FSM.
// Opens the door for a tick-timed window on a correct code and escalates to an alarmed lockout after repeated wrong codes.
module lock_status_ctrl #(
  parameter logic [7:0]  UNLOCK_TICKS  = 8'd50,
  parameter int unsigned MAX_FAIL      = 3,
  parameter logic [15:0] LOCKOUT_TICKS = 16'd600,
  parameter int unsigned TW            = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       step_en,
  input  logic       y,
  input  logic       ny,
  input  logic       lock_req,
  output logic       fsm_en,
  output logic       unlocked,
  output logic       locked_out,
  output logic       alarm,
  output logic [3:0] fail_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  localparam logic [3:0]    FAIL_LAST = 4'(MAX_FAIL - 1);
  localparam logic [3:0]    FAIL_MAX  = 4'(MAX_FAIL);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    fail_q, fail_d;
  logic          alarm_q, alarm_d;
  logic          y_q, ny_q;
  logic          y_rise, ny_rise;

  // Delayed copies reset to 0, so a flag already high at reset release counts as a rise.
  assign y_rise  = y & ~y_q;
  assign ny_rise = ny & ~ny_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOCKED;
      timer_q <= '0;
      fail_q  <= '0;
      alarm_q <= 1'b0;
      y_q     <= 1'b0;
      ny_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      alarm_q <= alarm_d;
      y_q     <= y;
      ny_q    <= ny;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    alarm_d = alarm_q;
    unique case (state_q)
      LOCKED: begin
        alarm_d = 1'b0;
        if (y_rise) begin
          state_d = OPEN;
          timer_d = TW'(UNLOCK_TICKS);
          fail_d  = '0;
        end else if (ny_rise && (fail_q == FAIL_LAST)) begin
          state_d = LOCKOUT;
          timer_d = TW'(LOCKOUT_TICKS);
          fail_d  = FAIL_MAX;
        end else if (ny_rise) begin
          fail_d = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
        end
      end
      OPEN: begin
        fail_d = '0;
        if (lock_req) begin
          state_d = LOCKED;
          timer_d = '0;
        end else if (tick && (timer_q == TIMER_ONE)) begin
          state_d = LOCKED;
          timer_d = '0;
        end else if (tick) begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      LOCKOUT: begin
        if (tick && (timer_q == TIMER_ONE)) begin
          state_d = LOCKED;
          timer_d = '0;
          fail_d  = '0;
          alarm_d = 1'b0;
        end else if (tick) begin
          timer_d = timer_q - TIMER_ONE;
          alarm_d = ~alarm_q;
        end
      end
      default: begin
        state_d = LOCKED;
        timer_d = '0;
        fail_d  = '0;
        alarm_d = 1'b0;
      end
    endcase
  end

  assign unlocked   = (state_q == OPEN);
  assign locked_out = (state_q == LOCKOUT);
  assign fsm_en     = step_en & ~locked_out;
  assign alarm      = alarm_q;
  assign fail_cnt   = fail_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_lock_status_ctrl.sv
// Directed scenarios for lock_status_ctrl with UNLOCK_TICKS=4, MAX_FAIL=3, LOCKOUT_TICKS=6, tick every 3 clk.
module tb_lock_status_ctrl;

  logic       clk;
  logic       reset_n;
  logic       tick;
  logic       step_en;
  logic       y;
  logic       ny;
  logic       lock_req;
  logic       fsm_en;
  logic       unlocked;
  logic       locked_out;
  logic       alarm;
  logic [3:0] fail_cnt;
  logic [1:0] state_dbg;

  int n_vec;
  int n_err;

  lock_status_ctrl #(
    .UNLOCK_TICKS (8'd4),
    .MAX_FAIL     (3),
    .LOCKOUT_TICKS(16'd6),
    .TW           (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .step_en   (step_en),
    .y         (y),
    .ny        (ny),
    .lock_req  (lock_req),
    .fsm_en    (fsm_en),
    .unlocked  (unlocked),
    .locked_out(locked_out),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one clock; inputs change and outputs are sampled 1 ns after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_period();
    tick = 1'b0;
    cyc();
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic ny_pulse();
    ny = 1'b1;
    cyc();
    cyc();
    ny = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step_en = 1'b1;
    cyc();
    cyc();
    n_vec++;
    if ({unlocked, locked_out, alarm, fail_cnt} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs got u=%b lo=%b al=%b fc=%0d exp all 0", unlocked, locked_out, alarm, fail_cnt);
    end
    n_vec++;
    if (fsm_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_fsm_en got %b exp 1", fsm_en);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    n_vec++;
    if (state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state got %0d exp 0", state_dbg);
    end
  endtask

  task automatic test_unlock();
    y = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_vec++;
      if (unlocked !== 1'b1 || fail_cnt !== 4'd0) begin
        n_err++;
        $display("FAIL t1_hold cyc=%0d got u=%b fc=%0d exp u=1 fc=0", i, unlocked, fail_cnt);
      end
    end
    y = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick_period();
      n_vec++;
      if (unlocked !== (k < 4)) begin
        n_err++;
        $display("FAIL t1_window tick=%0d got u=%b exp %b", k, unlocked, (k < 4));
      end
    end
    cyc();
    cyc();
    n_vec++;
    if (unlocked !== 1'b0 || fail_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL t1_after got u=%b fc=%0d exp u=0 fc=0", unlocked, fail_cnt);
    end
  endtask

  task automatic test_lockout();
    step_en = 1'b1;
    for (int p = 1; p <= 2; p++) begin
      ny_pulse();
      n_vec++;
      if (fail_cnt !== 4'(p) || locked_out !== 1'b0) begin
        n_err++;
        $display("FAIL t2_count pulse=%0d got fc=%0d lo=%b exp fc=%0d lo=0", p, fail_cnt, locked_out, p);
      end
    end
    ny = 1'b1;
    cyc();
    n_vec++;
    if (locked_out !== 1'b1 || fail_cnt !== 4'd3 || fsm_en !== 1'b0 || alarm !== 1'b0) begin
      n_err++;
      $display("FAIL t2_enter got lo=%b fc=%0d en=%b al=%b exp lo=1 fc=3 en=0 al=0", locked_out, fail_cnt, fsm_en, alarm);
    end
    cyc();
    ny = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick_period();
      n_vec++;
      if (k < 6) begin
        if (locked_out !== 1'b1 || alarm !== k[0] || fail_cnt !== 4'd3) begin
          n_err++;
          $display("FAIL t2_tick tick=%0d got lo=%b al=%b fc=%0d exp lo=1 al=%b fc=3", k, locked_out, alarm, fail_cnt, k[0]);
        end
      end else begin
        if (locked_out !== 1'b0 || alarm !== 1'b0 || fail_cnt !== 4'd0 || fsm_en !== 1'b1) begin
          n_err++;
          $display("FAIL t2_exit got lo=%b al=%b fc=%0d en=%b exp lo=0 al=0 fc=0 en=1", locked_out, alarm, fail_cnt, fsm_en);
        end
      end
    end
  endtask

  task automatic test_fail_then_open();
    ny_pulse();
    ny_pulse();
    n_vec++;
    if (fail_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL t3_two_fails got fc=%0d exp 2", fail_cnt);
    end
    y = 1'b1;
    cyc();
    y = 1'b0;
    cyc();
    n_vec++;
    if (unlocked !== 1'b1 || fail_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL t3_open got u=%b fc=%0d exp u=1 fc=0", unlocked, fail_cnt);
    end
    ny_pulse();
    n_vec++;
    if (unlocked !== 1'b1 || fail_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL t3_ny_in_open got u=%b fc=%0d exp u=1 fc=0", unlocked, fail_cnt);
    end
    lock_req = 1'b1;
    cyc();
    lock_req = 1'b0;
    n_vec++;
    if (unlocked !== 1'b0) begin
      n_err++;
      $display("FAIL t3_relock got u=%b exp 0", unlocked);
    end
  endtask

  task automatic test_lock_req();
    y = 1'b1;
    cyc();
    y = 1'b0;
    tick_period();
    n_vec++;
    if (unlocked !== 1'b1) begin
      n_err++;
      $display("FAIL t4_one_tick got u=%b exp 1", unlocked);
    end
    lock_req = 1'b1;
    cyc();
    lock_req = 1'b0;
    n_vec++;
    if (unlocked !== 1'b0 || state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL t4_lock_req got u=%b st=%0d exp u=0 st=0", unlocked, state_dbg);
    end
    cyc();
    y = 1'b1;
    cyc();
    y = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick_period();
      n_vec++;
      if (unlocked !== (k < 4)) begin
        n_err++;
        $display("FAIL t4_reopen tick=%0d got u=%b exp %b", k, unlocked, (k < 4));
      end
    end
  endtask

  task automatic test_simultaneous();
    ny_pulse();
    n_vec++;
    if (fail_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL t5_pre got fc=%0d exp 1", fail_cnt);
    end
    y  = 1'b1;
    ny = 1'b1;
    cyc();
    y  = 1'b0;
    ny = 1'b0;
    n_vec++;
    if (unlocked !== 1'b1 || fail_cnt !== 4'd0 || locked_out !== 1'b0) begin
      n_err++;
      $display("FAIL t5_both got u=%b fc=%0d lo=%b exp u=1 fc=0 lo=0", unlocked, fail_cnt, locked_out);
    end
    lock_req = 1'b1;
    cyc();
    lock_req = 1'b0;
    cyc();
    ny_pulse();
    ny_pulse();
    ny_pulse();
    n_vec++;
    if (locked_out !== 1'b1 || fail_cnt !== 4'd3) begin
      n_err++;
      $display("FAIL t5_lockout got lo=%b fc=%0d exp lo=1 fc=3", locked_out, fail_cnt);
    end
    y = 1'b1;
    cyc();
    y = 1'b0;
    cyc();
    n_vec++;
    if (unlocked !== 1'b0 || locked_out !== 1'b1) begin
      n_err++;
      $display("FAIL t5_y_in_lockout got u=%b lo=%b exp u=0 lo=1", unlocked, locked_out);
    end
  endtask

  task automatic test_async_reset();
    step_en = 1'b1;
    tick_period();
    n_vec++;
    if (locked_out !== 1'b1 || alarm !== 1'b1) begin
      n_err++;
      $display("FAIL t6_pre got lo=%b al=%b exp lo=1 al=1", locked_out, alarm);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (locked_out !== 1'b0 || alarm !== 1'b0 || fail_cnt !== 4'd0 || unlocked !== 1'b0) begin
      n_err++;
      $display("FAIL t6_async got lo=%b al=%b fc=%0d u=%b exp all 0", locked_out, alarm, fail_cnt, unlocked);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    cyc();
    n_vec++;
    if (fsm_en !== 1'b1) begin
      n_err++;
      $display("FAIL t6_en_hi got %b exp 1", fsm_en);
    end
    step_en = 1'b0;
    #1;
    n_vec++;
    if (fsm_en !== 1'b0) begin
      n_err++;
      $display("FAIL t6_en_lo got %b exp 0", fsm_en);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    tick     = 1'b0;
    step_en  = 1'b0;
    y        = 1'b0;
    ny       = 1'b0;
    lock_req = 1'b0;
    test_reset();
    test_unlock();
    test_lockout();
    test_fail_then_open();
    test_lock_req();
    test_simultaneous();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lock_status_ctrl.md
Name: lock_status_ctrl

Overview:
- Downstream stage of the combination-lock sequence FSM.
- Consumes the FSM's correct-code flag (y) and wrong-code flag (ny) and drives the door actuator (unlocked) for a timed window.
- Counts consecutive wrong codes and enters a timed lockout with alarm after MAX_FAIL failures.
- During lockout, withholds the step-enable it supplies to the sequence FSM, so keys are ignored.

Parameters:
- UNLOCK_TICKS, 8'd50: number of tick pulses the door stays unlocked; must be ≥1.
- MAX_FAIL, 3: consecutive wrong codes that trigger lockout; range 1..15.
- LOCKOUT_TICKS, 16'd600: number of tick pulses lockout lasts; must be ≥1.
- TW, 16: width of the tick timer; must hold max(UNLOCK_TICKS, LOCKOUT_TICKS).

Ports:
- clk, input, 1: system clock, all state on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- tick, input, 1: one-clk time-base strobe (e.g. 100 Hz).
- step_en, input, 1: upstream key-scan step strobe.
- y, input, 1: correct-code flag from the sequence FSM; level, may last several clk.
- ny, input, 1: wrong-code flag from the sequence FSM; level, may last several clk.
- lock_req, input, 1: manual relock request; level.
- fsm_en, output, 1: enable to the sequence FSM; equals step_en & ~locked_out (combinational).
- unlocked, output, 1: door actuator drive.
- locked_out, output, 1: lockout active.
- alarm, output, 1: alarm indicator; high in lockout, toggles each tick.
- fail_cnt, output, 4: current consecutive-failure count.

Behaviour:
- Reset (reset_n=0, async): state=LOCKED, timer=0, fail_cnt=0, y_d=ny_d=0, unlocked=0, locked_out=0, alarm=0.
- Edge detect: y_d, ny_d registered each clk; y_rise=y&~y_d; ny_rise=ny&~ny_d. A flag held high across many clk counts once. A flag already high at reset release counts as a rise.
- States:
  - LOCKED: unlocked=0.
    - y_rise → OPEN; timer<=UNLOCK_TICKS; fail_cnt<=0.
    - else ny_rise and fail_cnt==MAX_FAIL-1 → LOCKOUT; timer<=LOCKOUT_TICKS; fail_cnt<=MAX_FAIL.
    - else ny_rise → fail_cnt<=fail_cnt+1.
    - y_rise has priority over simultaneous ny_rise.
  - OPEN: unlocked=1.
    - lock_req=1 → LOCKED next clk; timer<=0.
    - else tick and timer==1 → LOCKED.
    - else tick → timer-1.
    - y_rise and ny_rise ignored; fail_cnt stays 0.
  - LOCKOUT: locked_out=1; fsm_en forced 0.
    - tick toggles alarm.
    - tick and timer==1 → LOCKED; fail_cnt<=0; alarm<=0.
    - else tick → timer-1.
    - y, ny and lock_req ignored.
- Outputs unlocked and locked_out are decoded from the registered state, so they assert 1 clk after the clk in which the rise is seen.
- Timed windows are exactly N ticks: the state is left on the clk of the Nth tick after entry. A tick on the entry clk itself is not counted.
- fail_cnt saturates and never wraps. The only paths to 0 are reset, successful unlock and lockout expiry.
- Illegal state encoding → LOCKED next clk, fail_cnt<=0.
- reset_n asserted mid-OPEN or mid-LOCKOUT: outputs drop immediately (async); the timer is discarded.

Test Plan:
Common setup: UNLOCK_TICKS=4, MAX_FAIL=3, LOCKOUT_TICKS=6, tick every 3 clk.
1. Hold y=1 for 5 clk → unlocked=1 from clk+1. It drops on the 4th tick after entry. Exactly one unlock, fail_cnt=0 throughout.
2. Three separate ny pulses (2 clk each) → fail_cnt 1, 2, then locked_out=1 with fail_cnt=3 and fsm_en=0 while step_en=1. Alarm toggles on each tick. After 6 ticks: locked_out=0, fail_cnt=0, alarm=0.
3. Two ny pulses, then a y pulse → unlocked=1, fail_cnt=0. A further ny during OPEN leaves fail_cnt=0.
4. In OPEN after 1 tick, lock_req=1 → unlocked=0 next clk. The state is LOCKED and a new y pulse re-opens for the full 4 ticks.
5. y and ny rise on the same clk in LOCKED → OPEN, fail_cnt=0. A y pulse during LOCKOUT → no unlock.
6. reset_n=0 for 1 clk mid-LOCKOUT (asynchronous, between edges) → locked_out=0, alarm=0, fail_cnt=0 immediately. fsm_en follows step_en after release.
